// File: rtl/hazard_pkg.sv
// Shared types and encodings for the hazard/destination tracker of the 8-register core.
package hazard_pkg;

    localparam int NUM_REGS = 8;
    localparam int REG_W    = $clog2(NUM_REGS);

    typedef struct packed {
        logic             v;
        logic [REG_W-1:0] rd;
        logic             ld;
    } slot_t;

    localparam logic [1:0] FWD_RF  = 2'b00;
    localparam logic [1:0] FWD_MEM = 2'b01;
    localparam logic [1:0] FWD_WB  = 2'b10;

    function automatic logic src_hit(input logic used, input logic [REG_W-1:0] src,
                                     input slot_t s);
        return used && s.v && (src == s.rd);
    endfunction

endpackage

// File: rtl/hazard_slot.sv
// One in-flight destination slot: async clear, hold while memory stalls, bubble on load.
module hazard_slot
    import hazard_pkg::*;
(
    input  logic  clk,
    input  logic  rst,
    input  logic  hold,
    input  logic  bubble,
    input  slot_t d,
    output slot_t q
);

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            q <= '0;
        else if (!hold)
            q <= bubble ? '0 : d;
    end

endmodule

// File: rtl/hazard_dest_tracker.sv
// Tracks in-flight destinations EX/MEM/WB and raises the decode stall on RAW hazards.
// Optional bypass selects and load-use-only stalling are enabled with `HAZARD_FWD_EN.
module hazard_dest_tracker
    import hazard_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             id_valid,
    input  logic [REG_W-1:0] id_rs,
    input  logic [REG_W-1:0] id_rt,
    input  logic             id_rs_used,
    input  logic             id_rt_used,
    input  logic [REG_W-1:0] id_rd,
    input  logic             id_ws_reg,
    input  logic             id_is_load,
    input  logic             flush,
    input  logic             mem_stall,
    output logic             stall,
    output logic [REG_W-1:0] wb_rd,
    output logic             wb_we,
`ifdef HAZARD_FWD_EN
    output logic [1:0]       ex_fwd_rs,
    output logic [1:0]       ex_fwd_rt,
`endif
    output logic [15:0]      stall_cnt
);

    function automatic logic [15:0] sat_inc(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

    slot_t ex_slot_p0, mem_slot_p1, wb_slot_p2;
    slot_t id_slot;
    logic  hit_ex, hit_mem;
    logic  issue, ex_load;

    assign hit_ex  = src_hit(id_rs_used, id_rs, ex_slot_p0)  || src_hit(id_rt_used, id_rt, ex_slot_p0);
    assign hit_mem = src_hit(id_rs_used, id_rs, mem_slot_p1) || src_hit(id_rt_used, id_rt, mem_slot_p1);

`ifdef HAZARD_FWD_EN
    // With bypassing only a load still in EX cannot supply its result in time.
    assign stall = id_valid && !flush && hit_ex && ex_slot_p0.ld;
`else
    assign stall = id_valid && !flush && (hit_ex || hit_mem);
`endif

    assign issue   = id_valid && !stall && !flush;
    assign ex_load = issue && id_ws_reg;
    assign id_slot = '{v: 1'b1, rd: id_rd, ld: id_is_load};

    // ID -> EX boundary
    hazard_slot u_slot_ex (
        .clk(clk), .rst(rst), .hold(mem_stall), .bubble(!ex_load),
        .d(id_slot), .q(ex_slot_p0)
    );

    // EX -> MEM boundary
    hazard_slot u_slot_mem (
        .clk(clk), .rst(rst), .hold(mem_stall), .bubble(1'b0),
        .d(ex_slot_p0), .q(mem_slot_p1)
    );

    // MEM -> WB boundary
    hazard_slot u_slot_wb (
        .clk(clk), .rst(rst), .hold(mem_stall), .bubble(1'b0),
        .d(mem_slot_p1), .q(wb_slot_p2)
    );

    assign wb_we = wb_slot_p2.v;
    assign wb_rd = wb_slot_p2.rd;

    // The load flag is only meaningful while the producer can still be in EX.
    logic unused_wb_ld;
    assign unused_wb_ld = wb_slot_p2.ld;

`ifdef HAZARD_FWD_EN
    function automatic logic [1:0] fwd_sel(input logic used, input logic [REG_W-1:0] src,
                                           input slot_t ex_s, input slot_t mem_s);
        if (src_hit(used, src, ex_s))
            return FWD_MEM;
        else if (src_hit(used, src, mem_s))
            return FWD_WB;
        return FWD_RF;
    endfunction

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ex_fwd_rs <= FWD_RF;
            ex_fwd_rt <= FWD_RF;
        end else if (!mem_stall) begin
            ex_fwd_rs <= issue ? fwd_sel(id_rs_used, id_rs, ex_slot_p0, mem_slot_p1) : FWD_RF;
            ex_fwd_rt <= issue ? fwd_sel(id_rt_used, id_rt, ex_slot_p0, mem_slot_p1) : FWD_RF;
        end
    end
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            stall_cnt <= '0;
        else if (stall && !mem_stall)
            stall_cnt <= sat_inc(stall_cnt);
    end

endmodule

// File: tb/tb_hazard_dest_tracker.sv
// Directed self-checking bench for hazard_dest_tracker (both with and without HAZARD_FWD_EN).
module tb_hazard_dest_tracker;
    import hazard_pkg::*;

    logic             clk = 1'b0;
    logic             rst;
    logic             id_valid;
    logic [REG_W-1:0] id_rs, id_rt, id_rd;
    logic             id_rs_used, id_rt_used, id_ws_reg, id_is_load;
    logic             flush, mem_stall;
    logic             stall, wb_we;
    logic [REG_W-1:0] wb_rd;
    logic [15:0]      stall_cnt;
`ifdef HAZARD_FWD_EN
    logic [1:0]       ex_fwd_rs, ex_fwd_rt;
`endif

    int errors = 0;
    int checks = 0;

    hazard_dest_tracker dut (
        .clk(clk), .rst(rst), .id_valid(id_valid),
        .id_rs(id_rs), .id_rt(id_rt), .id_rs_used(id_rs_used), .id_rt_used(id_rt_used),
        .id_rd(id_rd), .id_ws_reg(id_ws_reg), .id_is_load(id_is_load),
        .flush(flush), .mem_stall(mem_stall), .stall(stall),
        .wb_rd(wb_rd), .wb_we(wb_we),
`ifdef HAZARD_FWD_EN
        .ex_fwd_rs(ex_fwd_rs), .ex_fwd_rt(ex_fwd_rt),
`endif
        .stall_cnt(stall_cnt)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_id(input logic v, input logic [2:0] rs, input logic rsu,
                          input logic [2:0] rt, input logic rtu,
                          input logic [2:0] rd, input logic ws, input logic ld);
        id_valid = v; id_rs = rs; id_rs_used = rsu; id_rt = rt; id_rt_used = rtu;
        id_rd = rd; id_ws_reg = ws; id_is_load = ld;
        #1;
    endtask

    task automatic idle();
        set_id(1'b0, 3'd0, 1'b0, 3'd0, 1'b0, 3'd0, 1'b0, 1'b0);
    endtask

    task automatic drain();
        idle();
        repeat (4) tick();
    endtask

    task automatic test_reset();
        rst = 1'b1; flush = 1'b0; mem_stall = 1'b0;
        idle();
        tick(); tick();
        checks++; if (wb_we !== 1'b0) begin errors++; $display("FAIL reset_wb_we got=%b exp=0", wb_we); end
        checks++; if (wb_rd !== 3'd0) begin errors++; $display("FAIL reset_wb_rd got=%0d exp=0", wb_rd); end
        checks++; if (stall !== 1'b0) begin errors++; $display("FAIL reset_stall got=%b exp=0", stall); end
        checks++; if (stall_cnt !== 16'd0) begin errors++; $display("FAIL reset_cnt got=%0d exp=0", stall_cnt); end
`ifdef HAZARD_FWD_EN
        checks++; if (ex_fwd_rs !== 2'b00 || ex_fwd_rt !== 2'b00) begin errors++;
            $display("FAIL reset_fwd got=%b/%b exp=00/00", ex_fwd_rs, ex_fwd_rt); end
`endif
        rst = 1'b0;
        // ADD r3
        set_id(1'b1, 3'd1, 1'b1, 3'd2, 1'b1, 3'd3, 1'b1, 1'b0);
        tick();
        idle();
        checks++; if (wb_we !== 1'b0) begin errors++; $display("FAIL add_early_we got=%b exp=0", wb_we); end
        tick(); tick();
        checks++; if (wb_we !== 1'b1 || wb_rd !== 3'd3) begin errors++;
            $display("FAIL add_wb got we=%b rd=%0d exp we=1 rd=3", wb_we, wb_rd); end
        drain();
    endtask

    // Producer writes r6, (gap-1) non-writing fillers, then a consumer reading r6 via rs.
    task automatic test_distance(input int gap, input int exp_n, input logic [1:0] exp_fwd);
        int n;
        logic [15:0] cnt0;
        cnt0 = stall_cnt;
        set_id(1'b1, 3'd0, 1'b0, 3'd0, 1'b0, 3'd6, 1'b1, 1'b0);
        tick();
        for (int i = 1; i < gap; i++) begin
            set_id(1'b1, 3'd0, 1'b0, 3'd0, 1'b0, 3'd1, 1'b0, 1'b0);
            tick();
        end
        set_id(1'b1, 3'd6, 1'b1, 3'd0, 1'b0, 3'd4, 1'b1, 1'b0);
        n = 0;
        while (stall && n < 5) begin
            tick();
            n++;
        end
        checks++; if (n !== exp_n) begin errors++;
            $display("FAIL dist%0d_stalls got=%0d exp=%0d", gap, n, exp_n); end
        checks++; if (stall_cnt !== cnt0 + 16'(exp_n)) begin errors++;
            $display("FAIL dist%0d_cnt got=%0d exp=%0d", gap, stall_cnt, cnt0 + 16'(exp_n)); end
        tick();
        idle();
`ifdef HAZARD_FWD_EN
        checks++; if (ex_fwd_rs !== exp_fwd) begin errors++;
            $display("FAIL dist%0d_fwd got=%b exp=%b", gap, ex_fwd_rs, exp_fwd); end
`else
        checks++; if (exp_fwd === 2'b11) begin errors++; $display("FAIL dist%0d_arg got=%b", gap, exp_fwd); end
`endif
        tick(); tick();
        checks++; if (wb_we !== 1'b1 || wb_rd !== 3'd4) begin errors++;
            $display("FAIL dist%0d_wb got we=%b rd=%0d exp we=1 rd=4", gap, wb_we, wb_rd); end
        drain();
    endtask

    task automatic test_load_use(input int exp_n);
        int n;
        set_id(1'b1, 3'd0, 1'b0, 3'd0, 1'b0, 3'd2, 1'b1, 1'b1);
        tick();
        set_id(1'b1, 3'd2, 1'b1, 3'd5, 1'b0, 3'd3, 1'b1, 1'b0);
        n = 0;
        while (stall && n < 5) begin
            tick();
            n++;
        end
        checks++; if (n !== exp_n) begin errors++; $display("FAIL load_use_stalls got=%0d exp=%0d", n, exp_n); end
        tick();
        idle();
`ifdef HAZARD_FWD_EN
        checks++; if (ex_fwd_rs !== 2'b10) begin errors++; $display("FAIL load_use_fwd got=%b exp=10", ex_fwd_rs); end
`endif
        drain();
    endtask

    task automatic test_flush();
        logic [15:0] cnt0;
        cnt0 = stall_cnt;
        set_id(1'b1, 3'd0, 1'b0, 3'd0, 1'b0, 3'd2, 1'b1, 1'b0);
        tick();
        set_id(1'b1, 3'd2, 1'b1, 3'd2, 1'b1, 3'd7, 1'b1, 1'b0);
        flush = 1'b1; #1;
        checks++; if (stall !== 1'b0) begin errors++; $display("FAIL flush_stall got=%b exp=0", stall); end
        tick();
        flush = 1'b0;
        idle();
        tick();
        checks++; if (wb_we !== 1'b1 || wb_rd !== 3'd2) begin errors++;
            $display("FAIL flush_prod_wb got we=%b rd=%0d exp we=1 rd=2", wb_we, wb_rd); end
        tick();
        checks++; if (wb_we !== 1'b0) begin errors++; $display("FAIL flush_squashed_we got=%b exp=0", wb_we); end
        checks++; if (stall_cnt !== cnt0) begin errors++; $display("FAIL flush_cnt got=%0d exp=%0d", stall_cnt, cnt0); end
        drain();
    endtask

    task automatic test_mem_stall(input logic exp_stall);
        logic [15:0] cnt0;
        cnt0 = stall_cnt;
        set_id(1'b1, 3'd0, 1'b0, 3'd0, 1'b0, 3'd5, 1'b1, 1'b0);
        tick();
        idle();
        tick();
        mem_stall = 1'b1;
        set_id(1'b1, 3'd5, 1'b1, 3'd0, 1'b0, 3'd1, 1'b1, 1'b0);
        checks++; if (stall !== exp_stall) begin errors++;
            $display("FAIL memstall_comb got=%b exp=%b", stall, exp_stall); end
        repeat (4) begin
            tick();
            checks++; if (wb_we !== 1'b0 || stall_cnt !== cnt0) begin errors++;
                $display("FAIL memstall_frozen got we=%b cnt=%0d exp we=0 cnt=%0d", wb_we, stall_cnt, cnt0); end
        end
        mem_stall = 1'b0;
        idle();
        tick();
        checks++; if (wb_we !== 1'b1 || wb_rd !== 3'd5) begin errors++;
            $display("FAIL memstall_release got we=%b rd=%0d exp we=1 rd=5", wb_we, wb_rd); end
        drain();
    endtask

    task automatic test_no_write();
        int we_seen;
        // Branch-like: decoder reports rd=3 but no register write.
        set_id(1'b1, 3'd1, 1'b1, 3'd0, 1'b0, 3'd3, 1'b0, 1'b0);
        tick();
        set_id(1'b1, 3'd3, 1'b1, 3'd3, 1'b1, 3'd0, 1'b0, 1'b0);
        checks++; if (stall !== 1'b0) begin errors++; $display("FAIL nowrite_stall got=%b exp=0", stall); end
        tick();
        // JAL writes r7 like any other destination
        set_id(1'b1, 3'd0, 1'b0, 3'd0, 1'b0, 3'd7, 1'b1, 1'b0);
        tick();
        idle();
        we_seen = 0;
        for (int i = 0; i < 2; i++) begin
            tick();
            if (wb_we) we_seen++;
        end
        checks++; if (we_seen !== 1 || wb_rd !== 3'd7) begin errors++;
            $display("FAIL nowrite_we got writes=%0d rd=%0d exp writes=1 rd=7", we_seen, wb_rd); end
        drain();
    endtask

    task automatic test_midstream_reset();
        set_id(1'b1, 3'd0, 1'b0, 3'd0, 1'b0, 3'd4, 1'b1, 1'b0);
        tick();
        set_id(1'b1, 3'd0, 1'b0, 3'd0, 1'b0, 3'd5, 1'b1, 1'b0);
        tick();
        set_id(1'b1, 3'd5, 1'b1, 3'd4, 1'b1, 3'd1, 1'b1, 1'b0);
        checks++; if (stall !== 1'b1) begin errors++; $display("FAIL midrst_pre_stall got=%b exp=1", stall); end
        rst = 1'b1; #1;
        checks++; if (stall !== 1'b0) begin errors++; $display("FAIL midrst_stall got=%b exp=0", stall); end
        tick();
        checks++; if (wb_we !== 1'b0 || stall_cnt !== 16'd0) begin errors++;
            $display("FAIL midrst_state got we=%b cnt=%0d exp we=0 cnt=0", wb_we, stall_cnt); end
        rst = 1'b0;
        idle();
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++; if (wb_we !== 1'b0) begin errors++; $display("FAIL midrst_survivor cyc=%0d got=%b exp=0", i, wb_we); end
        end
    endtask

    initial begin
        test_reset();
`ifdef HAZARD_FWD_EN
        test_distance(1, 0, 2'b01);
        test_distance(2, 0, 2'b10);
        test_distance(3, 0, 2'b00);
        test_load_use(1);
        test_mem_stall(1'b0);
`else
        test_distance(1, 2, 2'b00);
        test_distance(2, 1, 2'b00);
        test_distance(3, 0, 2'b00);
        test_load_use(2);
        test_mem_stall(1'b1);
`endif
        test_flush();
        test_no_write();
        test_midstream_reset();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1);
    end

endmodule
